// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station: operand wakeup, lowest-index issue
module reservation_station #(
  parameter int         RS_SIZE = 4,
  parameter logic [4:0] NONE_OP = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op_in,
  input  logic [31:0] value1_in,
  input  logic [31:0] value2_in,
  input  logic [2:0]  query1_in,
  input  logic [2:0]  query2_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  target_in,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic [2:0]  mem_num,
  input  logic [31:0] mem_value,
  output logic        rs_full,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_imm,
  output logic [2:0]  alu_dest,
  output logic        overflow
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CW = $clog2(RS_SIZE + 1);

  logic [RS_SIZE-1:0] valid;
  logic [4:0]         op_q   [RS_SIZE];
  logic [31:0]        v1_q   [RS_SIZE];
  logic [31:0]        v2_q   [RS_SIZE];
  logic [31:0]        imm_q  [RS_SIZE];
  logic [2:0]         q1_q   [RS_SIZE];
  logic [2:0]         q2_q   [RS_SIZE];
  logic [2:0]         dest_q [RS_SIZE];

  logic               accept;
  logic               iss_hit;
  logic [IW-1:0]      iss_idx;
  logic               alloc_hit;
  logic [IW-1:0]      alloc_idx;
  logic [RS_SIZE-1:0] free_vec;
  logic [CW-1:0]      occ;
  logic [CW-1:0]      next_occ;
  logic               full_next;
  logic [31:0]        in_v1;
  logic [31:0]        in_v2;
  logic [2:0]         in_q1;
  logic [2:0]         in_q2;

  always_comb begin
    accept = (op_in <= 5'd13) || (op_in == 5'd17) || (op_in == 5'd26) || (op_in == 5'd27);
  end

  // Descending scans leave the lowest matching index selected.
  always_comb begin
    iss_hit = 1'b0;
    iss_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (valid[i] && q1_q[i] == 3'd0 && q2_q[i] == 3'd0) begin
        iss_hit = 1'b1;
        iss_idx = IW'(i);
      end
    end
  end

  always_comb begin
    free_vec = ~valid;
    if (iss_hit) free_vec[iss_idx] = 1'b1;
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = IW'(i);
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < RS_SIZE; i++) occ = occ + CW'(valid[i]);
    next_occ  = occ - CW'(iss_hit) + CW'(accept && alloc_hit);
    full_next = (CW'(RS_SIZE) - next_occ) <= CW'(1);
  end

  // Same-cycle broadcast bypass for the dispatched operands; ALU bus has priority.
  always_comb begin
    in_v1 = value1_in;
    in_q1 = query1_in;
    if (query1_in != 3'd0 && query1_in == alu_num) begin
      in_v1 = alu_value;
      in_q1 = 3'd0;
    end else if (query1_in != 3'd0 && query1_in == mem_num) begin
      in_v1 = mem_value;
      in_q1 = 3'd0;
    end
    in_v2 = value2_in;
    in_q2 = query2_in;
    if (query2_in != 3'd0 && query2_in == alu_num) begin
      in_v2 = alu_value;
      in_q2 = 3'd0;
    end else if (query2_in != 3'd0 && query2_in == mem_num) begin
      in_v2 = mem_value;
      in_q2 = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      rs_full  <= 1'b0;
      overflow <= 1'b0;
      alu_op   <= NONE_OP;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_imm  <= '0;
      alu_dest <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid[i] && q1_q[i] != 3'd0) begin
          if (q1_q[i] == alu_num) begin
            v1_q[i] <= alu_value;
            q1_q[i] <= 3'd0;
          end else if (q1_q[i] == mem_num) begin
            v1_q[i] <= mem_value;
            q1_q[i] <= 3'd0;
          end
        end
        if (valid[i] && q2_q[i] != 3'd0) begin
          if (q2_q[i] == alu_num) begin
            v2_q[i] <= alu_value;
            q2_q[i] <= 3'd0;
          end else if (q2_q[i] == mem_num) begin
            v2_q[i] <= mem_value;
            q2_q[i] <= 3'd0;
          end
        end
      end
      if (iss_hit) begin
        alu_op          <= op_q[iss_idx];
        alu_a           <= v1_q[iss_idx];
        alu_b           <= v2_q[iss_idx];
        alu_imm         <= imm_q[iss_idx];
        alu_dest        <= dest_q[iss_idx];
        valid[iss_idx]  <= 1'b0;
      end else begin
        alu_op   <= NONE_OP;
        alu_dest <= 3'd0;
      end
      // Allocation comes last so a slot freed by this edge's issue can be refilled.
      if (accept) begin
        if (alloc_hit) begin
          valid[alloc_idx]  <= 1'b1;
          op_q[alloc_idx]   <= op_in;
          v1_q[alloc_idx]   <= in_v1;
          q1_q[alloc_idx]   <= in_q1;
          v2_q[alloc_idx]   <= in_v2;
          q2_q[alloc_idx]   <= in_q2;
          imm_q[alloc_idx]  <= imm_in;
          dest_q[alloc_idx] <= target_in;
        end else begin
          overflow <= 1'b1;
        end
      end
      rs_full <= full_next;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - randomized scoreboard bench for reservation_station
module tb_reservation_station;
  localparam int         RS   = 4;
  localparam logic [4:0] NONE = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  logic [4:0]  op_in;
  logic [31:0] value1_in, value2_in, imm_in, alu_value, mem_value;
  logic [2:0]  query1_in, query2_in, target_in, alu_num, mem_num;
  logic        rs_full, overflow;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_imm;
  logic [2:0]  alu_dest;

  reservation_station #(.RS_SIZE(RS), .NONE_OP(NONE)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .value1_in(value1_in), .value2_in(value2_in),
    .query1_in(query1_in), .query2_in(query2_in), .imm_in(imm_in), .target_in(target_in),
    .alu_num(alu_num), .alu_value(alu_value), .mem_num(mem_num), .mem_value(mem_value),
    .rs_full(rs_full), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_dest(alu_dest), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [4:0]  op;
    logic [31:0] v1, v2, imm;
    logic [2:0]  q1, q2, dest;
  } ent_t;
  typedef struct {
    int          cyc;
    logic [4:0]  op;
    logic [31:0] a, b, imm;
    logic [2:0]  dest;
  } iss_t;
  typedef struct {
    int cyc;
    bit full, ovf;
  } st_t;

  ent_t  m [RS];
  iss_t  iq[$];
  st_t   sq[$];
  bit    m_ovf;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit is_alu_op(logic [4:0] op);
    return op inside {[5'd0:5'd13], 5'd17, 5'd26, 5'd27};
  endfunction

  // Resolve an operand tag against this cycle's broadcasts (ALU bus first).
  function automatic void resolve(inout logic [31:0] v, inout logic [2:0] q);
    if (q == 0) return;
    if (q == alu_num) begin v = alu_value; q = 0; end
    else if (q == mem_num) begin v = mem_value; q = 0; end
  endfunction

  // Predicts what the coming clock edge does given the inputs currently driven.
  task automatic model();
    int   slot, n;
    iss_t e;
    if (rst) begin
      foreach (m[i]) m[i].v = 0;
      m_ovf = 0;
      sq.push_back('{cyc + 1, 1'b0, 1'b0});
      return;
    end
    slot = -1;
    foreach (m[i]) if (slot < 0 && m[i].v && m[i].q1 == 0 && m[i].q2 == 0) slot = i;
    if (slot >= 0) begin
      e.cyc = cyc + 1; e.op = m[slot].op; e.a = m[slot].v1; e.b = m[slot].v2;
      e.imm = m[slot].imm; e.dest = m[slot].dest;
      iq.push_back(e);
      m[slot].v = 0;
    end
    foreach (m[i]) if (m[i].v) begin
      resolve(m[i].v1, m[i].q1);
      resolve(m[i].v2, m[i].q2);
    end
    if (is_alu_op(op_in)) begin
      slot = -1;
      foreach (m[i]) if (slot < 0 && !m[i].v) slot = i;
      if (slot < 0) m_ovf = 1;
      else begin
        m[slot].v = 1; m[slot].op = op_in; m[slot].imm = imm_in; m[slot].dest = target_in;
        m[slot].v1 = value1_in; m[slot].q1 = query1_in;
        m[slot].v2 = value2_in; m[slot].q2 = query2_in;
        resolve(m[slot].v1, m[slot].q1);
        resolve(m[slot].v2, m[slot].q2);
      end
    end
    n = 0;
    foreach (m[i]) n += m[i].v;
    sq.push_back('{cyc + 1, (RS - n) <= 1, m_ovf});
  endtask

  task automatic step(input bit r, input logic [4:0] op, input logic [31:0] a, b,
                      input logic [2:0] qa, qb, input logic [31:0] im, input logic [2:0] tg,
                      input logic [2:0] an, input logic [31:0] av,
                      input logic [2:0] mn, input logic [31:0] mv);
    rst = r; op_in = op; value1_in = a; value2_in = b; query1_in = qa; query2_in = qb;
    imm_in = im; target_in = tg; alu_num = an; alu_value = av; mem_num = mn; mem_value = mv;
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] an, input logic [31:0] av,
                      input logic [2:0] mn, input logic [31:0] mv);
    step(0, NONE, 0, 0, 0, 0, 0, 0, an, av, mn, mv);
  endtask

  // Monitor: per-cycle status and issued ops are popped and compared independently of the driver.
  always @(negedge clk) begin
    st_t  s;
    iss_t e;
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      chk("rs_full", 32'(rs_full), 32'(s.full));
      chk("overflow", 32'(overflow), 32'(s.ovf));
    end
    if (alu_op !== NONE) begin
      checks++;
      if (iq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue actual op=%0h dest=%0h expected no issue", alu_op, alu_dest);
      end else begin
        checks--;
        e = iq.pop_front();
        chk("issue_cycle", 32'(cyc), 32'(e.cyc));
        chk("alu_op", 32'(alu_op), 32'(e.op));
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_imm", alu_imm, e.imm);
        chk("alu_dest", 32'(alu_dest), 32'(e.dest));
      end
    end else begin
      chk("idle_dest", 32'(alu_dest), 32'd0);
      if (iq.size() > 0 && iq[0].cyc == cyc) begin
        e = iq.pop_front();
        chk("missing_issue_dest", 32'(alu_dest), 32'(e.dest));
      end
    end
  end

  initial begin
    logic [4:0] ops [12];
    ops = '{5'd0, 5'd1, 5'd5, 5'd8, 5'd13, 5'd17, 5'd26, 5'd27, 5'd14, 5'd20, NONE, NONE};
    foreach (m[i]) m[i].v = 0;
    m_ovf = 0;

    step(1, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_alu_op", 32'(alu_op), 32'(NONE));
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_alu_imm", alu_imm, 32'd0);

    // ADD with both operands ready
    step(0, 5'd0, 5, 7, 0, 0, 0, 3, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // SUB waiting on tag 2, woken two cycles later
    step(0, 5'd1, 0, 1, 2, 0, 0, 4, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(2, 10, 0, 0);
    idle(0, 0, 0, 0);
    // BEQ captured from a same-cycle memory broadcast
    step(0, 5'd8, 0, 9, 5, 0, 32'h1234, 2, 0, 0, 5, 32'h20);
    idle(0, 0, 0, 0);
    // Fill to full, overflow, then drain in index order
    for (int i = 1; i <= RS - 1; i++) step(0, 5'd1, 0, i, 6, 0, i, 3'(i), 0, 0, 0, 0);
    step(0, 5'd2, 0, 40, 6, 0, 40, 5, 0, 0, 0, 0);
    step(0, 5'd3, 0, 50, 6, 0, 50, 7, 0, 0, 0, 0);
    idle(6, 32'hABCD, 0, 0);
    for (int i = 0; i < RS + 1; i++) idle(0, 0, 0, 0);
    // Load and no-op are not stored
    step(0, 5'd14, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, NONE, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] qa, qb, an, mn;
      qa = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      qb = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      an = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      mn = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      step(i == 200 || i == 201, ops[$urandom_range(0, 11)], $urandom, $urandom, qa, qb,
           $urandom, 3'($urandom_range(1, 7)), an, $urandom, mn, $urandom);
    end
    for (int t = 1; t <= 7; t++) idle(3'(t), 32'(t * 3), 3'(8 - t), 32'(t * 5));
    for (int i = 0; i < RS + 2; i++) idle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("leftover_issues", 32'(iq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
